// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared packet record type and constants for the CAN RX packer
//
// Purpose: defines the packet record carried from the byte assembler through
//          the record FIFO to the host, plus the CAN payload size limit.
// Contents:
//   can_pkt_t      packed record {ide, id[28:0], len[3:0], data[63:0]} (98 bits)
//   CAN_MAX_BYTES  maximum number of payload bytes kept per frame
package can_pkg;

   localparam logic [3:0] CAN_MAX_BYTES = 4'd8;

   typedef struct packed {
      logic        ide;
      logic [28:0] id;
      logic [3:0]  len;
      logic [63:0] data;
   } can_pkt_t;

endpackage

// File: rtl/can_rx_pkt_fifo.sv
// rtl/can_rx_pkt_fifo.sv - show-ahead synchronous FIFO of CAN packet records
//
// Purpose: buffers assembled packet records; the head record is always
//          presented on head_o while the FIFO is not empty.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   push_i   in   write pkt_i (honoured when not full, or when a pop occurs)
//   pkt_i    in   record to write
//   pop_i    in   remove head record (ignored while empty)
//   head_o   out  record at head of FIFO
//   full_o   out  FIFO holds DEPTH records
//   empty_o  out  FIFO holds no records
module can_rx_pkt_fifo
   import can_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push_i,
   input  can_pkt_t pkt_i,
   input  logic     pop_i,
   output can_pkt_t head_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   can_pkt_t       mem_q [DEPTH];
   logic [AW:0]    wr_q, wr_d;
   logic [AW:0]    rd_q, rd_d;
   logic           do_push;
   logic           do_pop;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

   assign do_pop  = pop_i && !empty_o;
   // When full, a same-cycle pop frees the head slot, which is exactly the
   // slot the write pointer addresses, so the write can proceed.
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + PTR_ONE;
      if (do_pop)  rd_d = rd_q + PTR_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         if (do_push) mem_q[wr_q[AW-1:0]] <= pkt_i;
      end
   end

   assign head_o = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/can_rx_packer.sv
// rtl/can_rx_packer.sv - packs CAN RX bytes into records, buffers them, counts drops
//
// Purpose: assembles the bytes of one CAN frame into a packet record, queues
//          records in a small FIFO for the host and counts records discarded
//          because the FIFO was full.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_valid, rx_last        byte qualifier / last byte of frame
//   rx_data[7:0]             received byte
//   rx_id[28:0], rx_ide      frame ID and IDE flag, taken on the last byte
//   pkt_valid, pkt_ready     host handshake for the head record
//   pkt_ide, pkt_id, pkt_len, pkt_data   head record fields
//   drop_pulse               one-cycle pulse after a record is discarded
//   drop_cnt[DROP_W-1:0]     saturating count of discarded records
module can_rx_packer
   import can_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DROP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic              rx_last,
   input  logic [7:0]        rx_data,
   input  logic [28:0]       rx_id,
   input  logic              rx_ide,
   output logic              pkt_valid,
   input  logic              pkt_ready,
   output logic              pkt_ide,
   output logic [28:0]       pkt_id,
   output logic [3:0]        pkt_len,
   output logic [63:0]       pkt_data,
   output logic              drop_pulse,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam logic [DROP_W-1:0] CNT_MAX = {DROP_W{1'b1}};
   localparam logic [DROP_W-1:0] CNT_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

   logic [3:0]        count_q, count_d;
   logic [63:0]       data_q, data_d;
   logic [63:0]       merged;
   logic              push_req;
   can_pkt_t          rec;
   can_pkt_t          head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              drop;
   logic              drop_pulse_q;
   logic [DROP_W-1:0] drop_cnt_q;

   // Assembler: bytes beyond the eighth are silently ignored; the last byte
   // closes the record and leaves the shift register clean for the next frame.
   always_comb begin
      merged   = data_q;
      count_d  = count_q;
      data_d   = data_q;
      push_req = 1'b0;
      rec      = '0;
      if (count_q < CAN_MAX_BYTES) merged[{count_q[2:0], 3'b000} +: 8] = rx_data;
      if (rx_valid) begin
         if (rx_last) begin
            push_req = 1'b1;
            rec.ide  = rx_ide;
            rec.id   = rx_id;
            rec.len  = (count_q < CAN_MAX_BYTES) ? count_q + 4'd1 : CAN_MAX_BYTES;
            rec.data = merged;
            count_d  = '0;
            data_d   = '0;
         end else begin
            data_d = merged;
            if (count_q < CAN_MAX_BYTES) count_d = count_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         data_q  <= '0;
      end else begin
         count_q <= count_d;
         data_q  <= data_d;
      end
   end

   assign pkt_valid = !fifo_empty;
   assign pop       = pkt_valid && pkt_ready;
   assign drop      = push_req && fifo_full && !pop;

   can_rx_pkt_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_req),
      .pkt_i   (rec),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_pulse_q <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         drop_pulse_q <= drop;
         if (drop && (drop_cnt_q != CNT_MAX)) drop_cnt_q <= drop_cnt_q + CNT_ONE;
      end
   end

   assign pkt_ide    = head.ide;
   assign pkt_id     = head.id;
   assign pkt_len    = head.len;
   assign pkt_data   = head.data;
   assign drop_pulse = drop_pulse_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_can_rx_packer.sv
// tb/tb_can_rx_packer.sv - scoreboard bench for can_rx_packer
module tb_can_rx_packer;
   import can_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_valid = 1'b0;
   logic        rx_last = 1'b0;
   logic [7:0]  rx_data = '0;
   logic [28:0] rx_id = '0;
   logic        rx_ide = 1'b0;
   logic        pkt_ready = 1'b0;
   logic        pkt_valid;
   logic        pkt_ide;
   logic [28:0] pkt_id;
   logic [3:0]  pkt_len;
   logic [63:0] pkt_data;
   logic        drop_pulse;
   logic [15:0] drop_cnt;

   can_rx_packer #(.DEPTH(DEPTH), .DROP_W(16)) dut (
      .clk(clk), .rst(rst),
      .rx_valid(rx_valid), .rx_last(rx_last), .rx_data(rx_data),
      .rx_id(rx_id), .rx_ide(rx_ide),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
      .pkt_ide(pkt_ide), .pkt_id(pkt_id), .pkt_len(pkt_len), .pkt_data(pkt_data),
      .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   can_pkt_t   exp_q[$];
   logic [7:0] cur_bytes[$];
   int         exp_drops = 0;
   bit         push_now = 0;
   bit         drop_now = 0;
   bit         last_drop = 0;
   int         pulse_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: a frame is the list of its bytes; the record keeps the first
   // eight, and is accepted when the FIFO has room or its head leaves now.
   task automatic model_frame(input logic [28:0] id, input logic ide, input logic rdy);
      can_pkt_t rec;
      int n;
      n = cur_bytes.size();
      if (n > 8) n = 8;
      rec = '0;
      rec.ide = ide;
      rec.id  = id;
      rec.len = 4'(n);
      for (int i = 0; i < n; i++) rec.data[8*i +: 8] = cur_bytes[i];
      if (exp_q.size() < DEPTH || (exp_q.size() > 0 && rdy)) begin
         exp_q.push_back(rec);
         push_now = 1;
      end else begin
         exp_drops++;
         drop_now = 1;
      end
   endtask

   task automatic step(input logic v, input logic l, input logic [7:0] d,
                       input logic [28:0] id, input logic ide, input logic rdy);
      @(posedge clk); #1;
      rx_valid = v; rx_last = l; rx_data = d; rx_id = id; rx_ide = ide; pkt_ready = rdy;
      push_now = 0;
      drop_now = 0;
      if (v) begin
         cur_bytes.push_back(d);
         if (l) begin
            model_frame(id, ide, rdy);
            cur_bytes.delete();
         end
      end
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 1'b0, 8'h00, 29'h0, 1'b0, rdy);
   endtask

   task automatic send_frame(input int n, input logic [7:0] first, input logic [7:0] inc,
                             input logic [28:0] id, input logic ide, input logic rdy);
      logic [7:0] b;
      b = first;
      for (int i = 0; i < n; i++) begin
         step(1'b1, (i == n - 1), b, id, ide, rdy);
         b = b + inc;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      rx_valid = 1'b0; rx_last = 1'b0; pkt_ready = 1'b0;
      exp_q.delete();
      cur_bytes.delete();
      exp_drops = 0;
      push_now = 0;
      drop_now = 0;
      @(negedge clk);
      chk("rst_pkt_valid", 64'(pkt_valid), 64'd0);
      chk("rst_pkt_data", pkt_data, 64'd0);
      chk("rst_pkt_id_len_ide", {30'd0, pkt_ide, pkt_id, pkt_len}, 64'd0);
      chk("rst_drop", {47'd0, drop_pulse, drop_cnt}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0) break;
         idle(1'b1);
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      idle(1'b0);
   endtask

   // Monitor: compares the head record on every accepted handshake and
   // tracks valid / drop reporting each cycle, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         last_drop = 0;
      end else begin
         chk("pkt_valid", 64'(pkt_valid), 64'((exp_q.size() - int'(push_now)) > 0));
         chk("drop_pulse", 64'(drop_pulse), 64'(last_drop));
         chk("drop_cnt", 64'(drop_cnt), 64'(exp_drops - int'(drop_now)));
         if (drop_pulse) pulse_cnt++;
         last_drop = drop_now;
         if (pkt_valid && pkt_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_record", 64'd1, 64'd0);
            end else begin
               chk("rec_ide", 64'(pkt_ide), 64'(exp_q[0].ide));
               chk("rec_id", 64'(pkt_id), 64'(exp_q[0].id));
               chk("rec_len", 64'(pkt_len), 64'(exp_q[0].len));
               chk("rec_data", pkt_data, exp_q[0].data);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      int p0;
      logic v, l, rdy, ide;
      logic [28:0] id;

      do_reset();

      // Standard frame, four bytes, visible one cycle after the last byte.
      send_frame(4, 8'h11, 8'h11, 29'h001, 1'b0, 1'b1);
      idle(1'b1);
      @(negedge clk);
      chk("t1_valid", 64'(pkt_valid), 64'd1);
      chk("t1_len", 64'(pkt_len), 64'd4);
      chk("t1_data", pkt_data, 64'h44332211);
      chk("t1_ide", 64'(pkt_ide), 64'd0);
      drain();

      // Extended frame, eight bytes.
      send_frame(8, 8'h01, 8'h01, 29'h12345678, 1'b1, 1'b0);
      idle(1'b0);
      @(negedge clk);
      chk("t2_len", 64'(pkt_len), 64'd8);
      chk("t2_data", pkt_data, 64'h0807060504030201);
      chk("t2_id", 64'(pkt_id), 64'h12345678);
      chk("t2_ide", 64'(pkt_ide), 64'd1);
      drain();

      // Over-long frame truncated to eight bytes, then a clean single-byte frame.
      send_frame(10, 8'h01, 8'h01, 29'h0AB, 1'b0, 1'b0);
      send_frame(1, 8'hAA, 8'h00, 29'h0CD, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge clk);
      chk("t3_len", 64'(pkt_len), 64'd8);
      chk("t3_data", pkt_data, 64'h0807060504030201);
      drain();

      // FIFO overflow: DEPTH held, two dropped.
      p0 = pulse_cnt;
      for (int f = 0; f < DEPTH + 2; f++)
         send_frame(2, 8'(8'h20 + 8'(f) * 8'h10), 8'h01, 29'(f + 5), 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      @(negedge clk);
      chk("t4_drop_cnt", 64'(drop_cnt), 64'd2);
      chk("t4_pulses", 64'(pulse_cnt - p0), 64'd2);
      drain();

      // FIFO full; the completing byte coincides with a pop, so no drop.
      for (int f = 0; f < DEPTH; f++)
         send_frame(1, 8'(8'h60 + 8'(f)), 8'h00, 29'(f + 16), 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'h77, 29'h3FF, 1'b0, 1'b1);
      idle(1'b0);
      idle(1'b0);
      @(negedge clk);
      chk("t5_drop_cnt", 64'(drop_cnt), 64'd2);
      chk("t5_held", 64'(exp_q.size()), 64'(DEPTH));
      drain();

      // Reset in the middle of a frame.
      send_frame(3, 8'hE1, 8'h01, 29'h100, 1'b0, 1'b0);
      rx_last = 1'b0;
      do_reset();
      send_frame(2, 8'h5A, 8'h01, 29'h101, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge clk);
      chk("t6_len", 64'(pkt_len), 64'd2);
      chk("t6_data", pkt_data, 64'h5B5A);
      drain();

      // Random traffic with bursts of host back-pressure.
      for (int c = 0; c < 600; c++) begin
         v   = ($urandom_range(0, 3) != 0);
         l   = v && ($urandom_range(0, 5) == 0);
         rdy = ((c / 60) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
         ide = 1'($urandom_range(0, 1));
         id  = ide ? 29'($urandom) : 29'($urandom_range(0, 2047));
         step(v, l, 8'($urandom), id, ide, rdy);
      end
      step(1'b1, 1'b1, 8'hF0, 29'h7FF, 1'b0, 1'b0);
      drain();
      idle(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
